// File: rtl/block_mem.sv
// Block memory with a fixed multi-cycle access latency and a power-up clear sweep.
// Requests are accepted in IDLE, serviced after LATENCY edges, then acknowledged by a one-cycle DONE.
module block_mem #(
  parameter int unsigned LATENCY = 100,
  parameter int unsigned DEPTH   = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [6:0]  address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        busy_wait
);

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [AW-1:0]  r_clr_idx;
  logic [CW-1:0]  r_cnt;
  logic           r_op_wr;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [DW-1:0]  r_read_data;
  logic [DW-1:0]  r_mem [DEPTH];

  logic           w_req;
  logic           w_clr_last;
  logic           w_cnt_zero;
  logic           w_busy;
  logic           w_latch;
  logic           w_mem_we;
  logic [AW-1:0]  w_mem_addr;
  logic [DW-1:0]  w_mem_wdata;
  logic           w_rd_load;

  // Only an unambiguous request (exactly one of read/write) counts.
  assign w_req      = read ^ write;
  assign w_clr_last = (r_clr_idx == AW'(DEPTH - 1));
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CLEAR;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CLEAR:   if (w_clr_last) w_next_state = IDLE;
      IDLE:    if (w_req)      w_next_state = ACCESS;
      ACCESS:  if (w_cnt_zero) w_next_state = DONE;
      DONE:                    w_next_state = IDLE;
      default:                 w_next_state = CLEAR;
    endcase
  end

  always_comb begin
    w_busy      = 1'b0;
    w_latch     = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_addr;
    w_mem_wdata = r_wdata;
    w_rd_load   = 1'b0;
    case (r_state)
      CLEAR: begin
        w_busy      = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_idx;
        w_mem_wdata = '0;
      end
      IDLE: begin
        w_busy  = w_req;
        w_latch = w_req;
      end
      ACCESS: begin
        w_busy    = 1'b1;
        w_mem_we  = w_cnt_zero & r_op_wr;
        w_rd_load = w_cnt_zero & ~r_op_wr;
      end
      default: ;
    endcase
  end

  // Request capture and latency countdown; inputs are ignored once latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_idx   <= '0;
      r_cnt       <= '0;
      r_op_wr     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
    end else begin
      if (r_state == CLEAR) r_clr_idx <= r_clr_idx + AW'(1);
      if (w_latch) begin
        r_cnt   <= CW'(LATENCY - 1);
        r_op_wr <= write;
        r_addr  <= address;
        r_wdata <= write_data;
      end else if (r_state == ACCESS && !w_cnt_zero) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_rd_load) r_read_data <= r_mem[r_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  assign read_data = r_read_data;
  assign busy_wait = w_busy;

endmodule

// File: tb/tb_block_mem.sv
// Scoreboard bench for block_mem: one instance at LATENCY=4, a second at LATENCY=1.
module tb_block_mem;

  localparam int unsigned DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst4, rst1;
  logic        read, write;
  logic [6:0]  address;
  logic [15:0] write_data;
  logic [15:0] rd4, rd1;
  logic        busy4, busy1;

  always #5 clk = ~clk;

  block_mem #(.LATENCY(4), .DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .rst(rst4), .read(read), .write(write), .address(address),
    .write_data(write_data), .read_data(rd4), .busy_wait(busy4)
  );

  block_mem #(.LATENCY(1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst1), .read(read), .write(write), .address(address),
    .write_data(write_data), .read_data(rd1), .busy_wait(busy1)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic        sel   = 1'b0;
  int          lat   = 4;
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_rd;
  logic [15:0] exp_q [$];

  wire         busy = sel ? busy1 : busy4;
  wire  [15:0] rd   = sel ? rd1 : rd4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (lat=%0d)", tag, got, exp, lat);
    end
  endtask

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_rd = '0;
    exp_q.delete();
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst1 = v;
    else     rst4 = v;
  endtask

  // Release reset at a falling edge and count the cycles busy stays high.
  task automatic wait_clear();
    int n;
    set_rst(1'b1);
    #1;
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("clear_len", 32'(n), 32'(DEPTH));
  endtask

  task automatic access(input logic wr, input logic [6:0] a, input logic [15:0] d,
                        input bit hold, input bit scramble);
    logic [15:0] e;
    @(negedge clk);
    read = ~wr; write = wr; address = a; write_data = d;
    #1;
    check("req_busy", 32'(busy), 32'd1);
    if (wr) m_mem[a] = d;
    else    exp_q.push_back(m_mem[a]);
    @(posedge clk);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check("acc_busy", 32'(busy), 32'd1);
      if (scramble) begin
        address    = 7'(a + 7'd1);
        write_data = 16'hFFFF;
      end
    end
    @(negedge clk);
    #1;
    check("done_busy", 32'(busy), 32'd0);
    if (!wr) begin
      if (exp_q.size() == 0) begin
        check("q_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        m_rd = e;
        check("rd_data", 32'(rd), 32'(e));
      end
    end else begin
      check("wr_keeps_rd", 32'(rd), 32'(m_rd));
    end
    if (!hold) begin
      read = 1'b0; write = 1'b0;
    end
  endtask

  // Start a write, then pull reset after n_edges rising edges, before it can commit.
  task automatic abort_write(input logic [6:0] a, input logic [15:0] d, input int n_edges);
    @(negedge clk);
    read = 1'b0; write = 1'b1; address = a; write_data = d;
    repeat (n_edges) @(posedge clk);
    #1;
    set_rst(1'b0);
    #1;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_rd", 32'(rd), 32'd0);
    model_reset();
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    wait_clear();
  endtask

  initial begin
    rst4 = 1'b0; rst1 = 1'b0;
    read = 1'b0; write = 1'b0; address = '0; write_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy4", 32'(busy4), 32'd1);
    check("rst_rd4", 32'(rd4), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd1);
    check("rst_rd1", 32'(rd1), 32'd0);

    wait_clear();
    access(1'b0, 7'h7F, 16'h0, 1'b0, 1'b0);
    access(1'b1, 7'h05, 16'hBEEF, 1'b0, 1'b0);
    access(1'b0, 7'h05, 16'h0, 1'b0, 1'b0);
    access(1'b1, 7'h05, 16'h1234, 1'b0, 1'b1);
    access(1'b0, 7'h05, 16'h0, 1'b0, 1'b0);
    access(1'b0, 7'h06, 16'h0, 1'b0, 1'b0);
    access(1'b0, 7'h05, 16'h0, 1'b0, 1'b0);

    // Conflicting request must be ignored while sitting in IDLE.
    @(negedge clk);
    read = 1'b1; write = 1'b1; address = 7'h06; write_data = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("both_busy", 32'(busy), 32'd0);
      check("both_rd", 32'(rd), 32'(m_rd));
      @(negedge clk);
    end
    read = 1'b0; write = 1'b0;
    access(1'b0, 7'h06, 16'h0, 1'b0, 1'b0);
    access(1'b0, 7'h05, 16'h0, 1'b0, 1'b0);

    // Held read gives back-to-back accesses with a single low DONE cycle.
    access(1'b0, 7'h05, 16'h0, 1'b1, 1'b0);
    access(1'b0, 7'h05, 16'h0, 1'b0, 1'b0);

    abort_write(7'h10, 16'hAAAA, 3);
    access(1'b0, 7'h10, 16'h0, 1'b0, 1'b0);
    access(1'b0, 7'h05, 16'h0, 1'b0, 1'b0);

    // Single-cycle ACCESS instance.
    @(negedge clk);
    rst4 = 1'b0;
    sel  = 1'b1;
    lat  = 1;
    model_reset();
    wait_clear();
    access(1'b1, 7'h10, 16'hAAAA, 1'b0, 1'b0);
    access(1'b0, 7'h10, 16'h0, 1'b0, 1'b0);
    access(1'b1, 7'h11, 16'h7777, 1'b0, 1'b1);
    access(1'b0, 7'h12, 16'h0, 1'b0, 1'b0);
    access(1'b0, 7'h11, 16'h0, 1'b0, 1'b0);
    abort_write(7'h10, 16'h5555, 1);
    access(1'b0, 7'h10, 16'h0, 1'b0, 1'b0);
    access(1'b0, 7'h11, 16'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
